// File: rtl/board_store.sv
// board_store: storage end of the board-change write interface.
// Holds the 64-square chess board (4 bits per square = {color, piece}), commits
// single-square writes, rebuilds the initial position with a 64-cycle sweep, serves a
// registered random read port and exposes the whole board as a flat bus.
//
// Ports:
//   i_clk        clock (only clock)
//   i_reset      synchronous active-high reset
//   i_init_req   pulse: rebuild the initial position
//   i_wr_en      write request, taken only while o_wr_ready=1
//   i_wr_addr    square to write (row*8 + col)
//   i_wr_piece   new square contents
//   o_wr_ready   1 when a write is accepted this cycle (= ~o_busy)
//   i_rd_en      read request
//   i_rd_addr    square to read
//   o_rd_piece   read data, registered
//   o_rd_valid   1 the cycle after i_rd_en
//   o_board      flat board, square i at [4i+3:4i]
//   o_busy       1 while the init sweep runs
//   o_wr_count   accepted writes since the last init, saturating
module board_store #(
  parameter int unsigned NUM_SQ  = 64,
  parameter int unsigned PIECE_W = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_init_req,
  input  logic                        i_wr_en,
  input  logic [$clog2(NUM_SQ)-1:0]   i_wr_addr,
  input  logic [PIECE_W-1:0]          i_wr_piece,
  output logic                        o_wr_ready,
  input  logic                        i_rd_en,
  input  logic [$clog2(NUM_SQ)-1:0]   i_rd_addr,
  output logic [PIECE_W-1:0]          o_rd_piece,
  output logic                        o_rd_valid,
  output logic [NUM_SQ*PIECE_W-1:0]   o_board,
  output logic                        o_busy,
  output logic [CNT_W-1:0]            o_wr_count
);

  localparam int unsigned ADDR_W = $clog2(NUM_SQ);

  typedef enum logic {StIdle, StInit} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic [CNT_W-1:0]    r_wr_count;
  logic [PIECE_W-1:0]  r_rd_piece;
  logic                r_rd_valid;
  logic [PIECE_W-1:0]  r_mem [NUM_SQ];

  logic w_sweep_we;
  logic w_wr_accept;

  // Starting contents of a square: row 0 black back rank, row 1 black pawns,
  // row 6 white pawns, row 7 white back rank, everything else empty.
  function automatic logic [PIECE_W-1:0] init_val(input logic [ADDR_W-1:0] sq);
    logic [2:0] w_back;
    unique case (sq[2:0])
      3'd0, 3'd7: w_back = 3'd4;  // rook
      3'd1, 3'd6: w_back = 3'd2;  // knight
      3'd2, 3'd5: w_back = 3'd3;  // bishop
      3'd3:       w_back = 3'd5;  // queen
      default:    w_back = 3'd6;  // king
    endcase
    unique case (sq[5:3])
      3'd0:    init_val = {1'b1, w_back};
      3'd1:    init_val = 4'h9;
      3'd6:    init_val = 4'h1;
      3'd7:    init_val = {1'b0, w_back};
      default: init_val = 4'h0;
    endcase
  endfunction

  assign w_sweep_we  = (r_state == StInit);
  // INIT_REQ wins over a simultaneous write.
  assign w_wr_accept = (r_state == StIdle) && i_wr_en && !i_init_req;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StInit;
      r_idx      <= '0;
      r_wr_count <= '0;
      r_rd_piece <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      // Nonblocking read of r_mem gives read-first behaviour against a same-edge write.
      if (i_rd_en) begin
        r_rd_piece <= r_mem[i_rd_addr];
      end
      unique case (r_state)
        StInit: begin
          if (i_init_req) begin
            r_idx      <= '0;
            r_wr_count <= '0;
          end else if (r_idx == ADDR_W'(NUM_SQ - 1)) begin
            r_state <= StIdle;
          end else begin
            r_idx <= r_idx + ADDR_W'(1);
          end
        end
        StIdle: begin
          if (i_init_req) begin
            r_state    <= StInit;
            r_idx      <= '0;
            r_wr_count <= '0;
          end else if (w_wr_accept && (r_wr_count != '1)) begin
            r_wr_count <= r_wr_count + CNT_W'(1);
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  // Storage has no reset; its contents come from the sweep.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (w_sweep_we) begin
        r_mem[r_idx] <= init_val(r_idx);
      end else if (w_wr_accept) begin
        r_mem[i_wr_addr] <= i_wr_piece;
      end
    end
  end

  always_comb begin
    o_board = '0;
    for (int i = 0; i < NUM_SQ; i++) begin
      o_board[i*PIECE_W +: PIECE_W] = r_mem[i];
    end
  end

  assign o_busy     = (r_state == StInit);
  assign o_wr_ready = (r_state == StIdle);
  assign o_rd_piece = r_rd_piece;
  assign o_rd_valid = r_rd_valid;
  assign o_wr_count = r_wr_count;

endmodule

// File: tb/tb_board_store.sv
module tb_board_store;

  logic         clk;
  logic         reset;
  logic         init_req;
  logic         wr_en;
  logic [5:0]   wr_addr;
  logic [3:0]   wr_piece;
  logic         wr_ready;
  logic         rd_en;
  logic [5:0]   rd_addr;
  logic [3:0]   rd_piece;
  logic         rd_valid;
  logic [255:0] board;
  logic         busy;
  logic [7:0]   wr_count;

  board_store dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_init_req (init_req),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_piece (wr_piece),
    .o_wr_ready (wr_ready),
    .i_rd_en    (rd_en),
    .i_rd_addr  (rd_addr),
    .o_rd_piece (rd_piece),
    .o_rd_valid (rd_valid),
    .o_board    (board),
    .o_busy     (busy),
    .o_wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: board contents plus which squares hold defined values.
  logic [3:0] m_mem [64];
  bit         m_known [64];
  bit         m_busy;
  int         m_pos;
  int         m_count;
  bit         m_rv;
  logic [3:0] m_rp;
  bit         m_rp_known;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_init(input int sq);
    int rank [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    int row = sq / 8;
    int col = sq % 8;
    if (row == 0) return 4'(8 + rank[col]);
    if (row == 1) return 4'd9;
    if (row == 6) return 4'd1;
    if (row == 7) return 4'(rank[col]);
    return 4'd0;
  endfunction

  function automatic logic [255:0] init_board();
    logic [255:0] v;
    for (int i = 0; i < 64; i++) v[i*4 +: 4] = ref_init(i);
    return v;
  endfunction

  // Apply current inputs across one rising edge, advance the model, compare everything.
  task automatic run_cycle();
    logic [255:0] exp_b;
    logic [255:0] mask;
    @(posedge clk);
    if (reset) begin
      m_busy = 1; m_pos = 0; m_count = 0; m_rv = 0; m_rp = 0; m_rp_known = 1;
    end else begin
      m_rv = rd_en;
      if (rd_en) begin
        m_rp       = m_mem[rd_addr];
        m_rp_known = m_known[rd_addr];
      end
      if (m_busy) begin
        m_mem[m_pos]   = ref_init(m_pos);
        m_known[m_pos] = 1;
        if (init_req) begin
          m_pos = 0; m_count = 0;
        end else if (m_pos == 63) begin
          m_busy = 0;
        end else begin
          m_pos++;
        end
      end else if (init_req) begin
        m_busy = 1; m_pos = 0; m_count = 0;
      end else if (wr_en) begin
        m_mem[wr_addr]   = wr_piece;
        m_known[wr_addr] = 1;
        if (m_count < 255) m_count++;
      end
    end
    #1;
    check("busy", 256'(busy), 256'(m_busy));
    check("wr_ready", 256'(wr_ready), 256'(!m_busy));
    check("wr_count", 256'(wr_count), 256'(m_count));
    check("rd_valid", 256'(rd_valid), 256'(m_rv));
    if (m_rp_known) check("rd_piece", 256'(rd_piece), 256'(m_rp));
    exp_b = '0;
    mask  = '0;
    for (int i = 0; i < 64; i++) begin
      if (m_known[i]) begin
        exp_b[i*4 +: 4] = m_mem[i];
        mask[i*4 +: 4]  = 4'hf;
      end
    end
    check("board", board & mask, exp_b);
  endtask

  task automatic idle_inputs();
    init_req = 0; wr_en = 0; rd_en = 0; reset = 0;
  endtask

  // Runs up to 80 cycles and returns the edge count at which BUSY first drops (0 if never).
  task automatic busy_len(output int len);
    len = 0;
    for (int i = 1; i <= 80; i++) begin
      run_cycle();
      if (!busy && len == 0) len = i;
    end
  endtask

  initial begin
    int len;
    for (int i = 0; i < 64; i++) begin
      m_mem[i] = 0; m_known[i] = 0;
    end
    m_busy = 1; m_pos = 0; m_count = 0; m_rv = 0; m_rp = 0; m_rp_known = 0;
    wr_addr = 0; wr_piece = 0; rd_addr = 0;
    idle_inputs();

    // Test 1: reset then sweep
    reset = 1;
    @(negedge clk);
    run_cycle();
    check("t1_reset_busy", 256'(busy), 256'(1));
    check("t1_reset_count", 256'(wr_count), 256'(0));
    check("t1_reset_rv", 256'(rd_valid), 256'(0));
    check("t1_reset_rp", 256'(rd_piece), 256'(0));
    reset = 0;
    busy_len(len);
    check("t1_busy_len", 256'(len), 256'(64));
    check("t1_sq0", 256'(board[3:0]), 256'(4'hC));
    check("t1_sq4", 256'(board[19:16]), 256'(4'hE));
    check("t1_sq60", 256'(board[243:240]), 256'(4'h6));
    check("t1_sq52", 256'(board[211:208]), 256'(4'h1));
    check("t1_sq35", 256'(board[143:140]), 256'(4'h0));
    check("t1_board", board, init_board());

    // Test 2: two writes then a read
    wr_en = 1; wr_addr = 52; wr_piece = 0;
    run_cycle();
    wr_addr = 36; wr_piece = 1;
    run_cycle();
    wr_en = 0;
    check("t2_sq52", 256'(board[52*4 +: 4]), 256'(0));
    check("t2_sq36", 256'(board[36*4 +: 4]), 256'(1));
    check("t2_count", 256'(wr_count), 256'(2));
    rd_en = 1; rd_addr = 36;
    run_cycle();
    rd_en = 0;
    check("t2_rd_piece", 256'(rd_piece), 256'(1));
    check("t2_rd_valid", 256'(rd_valid), 256'(1));
    run_cycle();
    check("t2_rd_valid_off", 256'(rd_valid), 256'(0));
    check("t2_rd_hold", 256'(rd_piece), 256'(1));

    // Test 3: write during sweep is ignored
    init_req = 1;
    run_cycle();
    init_req = 0;
    wr_en = 1; wr_addr = 20; wr_piece = 5;
    check("t3_wr_ready", 256'(wr_ready), 256'(0));
    run_cycle();
    wr_en = 0;
    for (int i = 0; i < 64; i++) run_cycle();
    check("t3_sq20", 256'(board[20*4 +: 4]), 256'(0));
    check("t3_count", 256'(wr_count), 256'(0));

    // Test 4: restart at sweep idx 30
    init_req = 1;
    run_cycle();
    init_req = 0;
    for (int i = 0; i < 30; i++) run_cycle();
    init_req = 1;
    run_cycle();
    init_req = 0;
    check("t4_busy_restart", 256'(busy), 256'(1));
    busy_len(len);
    check("t4_busy_len", 256'(len), 256'(64));
    check("t4_board", board, init_board());

    // Test 5: same-edge read and write are read-first
    wr_en = 1; wr_addr = 8; wr_piece = 0; rd_en = 1; rd_addr = 8;
    run_cycle();
    wr_en = 0;
    check("t5_old", 256'(rd_piece), 256'(9));
    run_cycle();
    rd_en = 0;
    check("t5_new", 256'(rd_piece), 256'(0));

    // Test 6: counter saturation and clear
    for (int i = 0; i < 300; i++) begin
      wr_en = 1; wr_addr = 6'($urandom_range(63)); wr_piece = 4'($urandom_range(15));
      run_cycle();
    end
    wr_en = 0;
    check("t6_sat", 256'(wr_count), 256'(255));
    init_req = 1;
    run_cycle();
    init_req = 0;
    check("t6_clear", 256'(wr_count), 256'(0));
    for (int i = 0; i < 64; i++) run_cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(999) == 0);
      init_req = ($urandom_range(199) == 0);
      wr_en    = $urandom_range(1) == 1;
      wr_addr  = 6'($urandom_range(63));
      wr_piece = 4'($urandom_range(15));
      rd_en    = $urandom_range(1) == 1;
      rd_addr  = ($urandom_range(3) == 0) ? wr_addr : 6'($urandom_range(63));
      run_cycle();
    end
    idle_inputs();
    run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
